// File: rtl/a25_copro15_regfile.sv
// CP15 register file for Amber 25: cache control, region maps, fault capture, flush sequencer.
// Define A25_COPRO_FAULT_QUEUE_EN to replace the single fault register with a FAULT_DEPTH FIFO.
module a25_copro15_regfile #(
  parameter int NUM_REGIONS  = 32,
  parameter int REGION_SHIFT = 21,
  parameter int FAULT_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_enable,
  input  logic        test_mode,
  input  logic        i_core_stall,
  input  logic [3:0]  i_copro_crn,
  input  logic [1:0]  i_copro_operation,
  input  logic [31:0] i_copro_write_data,
  input  logic        i_fault,
  input  logic [7:0]  i_fault_status,
  input  logic [31:0] i_fault_address,
  input  logic        i_access_valid,
  input  logic [31:0] i_access_address,
  input  logic        i_cache_flush_ack,
  output logic [31:0] o_copro_read_data,
  output logic        o_cache_enable,
  output logic [31:0] o_cacheable_area,
  output logic        o_cache_flush_req,
  output logic        o_flush_busy
);

  localparam logic [31:0] MAP_MASK = 32'hFFFF_FFFF >> (32 - NUM_REGIONS);

  typedef enum logic [1:0] {FL_IDLE, FL_REQ, FL_WAIT} flush_state_t;

  flush_state_t r_flush_state;
  logic         r_flush_pend;
  logic         r_flush_req;
  logic         r_flush_busy;
  logic [2:0]   r_cache_control;
  logic [31:0]  r_cacheable;
  logic [31:0]  r_updateable;
  logic [31:0]  r_disruptive;
  logic [31:0]  r_read_data;

  logic         w_mcr;
  logic         w_mrc;
  logic         w_fault_take;
  logic [31:0]  w_region_idx;
  logic         w_disruptive_hit;
  logic         w_trigger;
  logic [31:0]  w_read_mux;
  logic [7:0]   w_head_status;
  logic [31:0]  w_head_addr;
  logic [3:0]   w_fault_cnt;
  logic         w_fault_ovf;
  logic         w_fault_empty;
  logic         w_unused;

  assign w_mcr        = !i_core_stall && (i_copro_operation == 2'd2);
  assign w_mrc        = !i_core_stall && (i_copro_operation == 2'd1);
  assign w_fault_take = !i_core_stall && i_fault;

  // Regions past NUM_REGIONS never hit, even though the map bits there are already zero.
  assign w_region_idx     = i_access_address >> REGION_SHIFT;
  assign w_disruptive_hit = (w_region_idx < 32'(NUM_REGIONS)) && r_disruptive[w_region_idx[4:0]];
  assign w_trigger        = (w_mcr && (i_copro_crn == 4'd1)) ||
                            (!i_core_stall && i_access_valid && r_cache_control[0] && w_disruptive_hit);

`ifdef A25_COPRO_FAULT_QUEUE_EN
  localparam int PTR_W = $clog2(FAULT_DEPTH);

  logic [7:0]     r_q_status [FAULT_DEPTH];
  logic [31:0]    r_q_addr   [FAULT_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0] r_count;
  logic           r_ovf;
  logic           w_pop;
  logic           w_push;
  logic           w_full;
  logic [4:0]     w_cnt5;

  assign w_full  = (r_count == (PTR_W+1)'(FAULT_DEPTH));
  assign w_pop   = w_mrc && (i_copro_crn == 4'd7) && (r_count != '0);
  assign w_push  = w_fault_take && (!w_full || w_pop);
  assign w_cnt5  = 5'(r_count);

  assign w_fault_empty = (r_count == '0);
  assign w_fault_ovf   = r_ovf;
  assign w_fault_cnt   = (w_cnt5 > 5'd15) ? 4'd15 : w_cnt5[3:0];
  assign w_head_status = w_fault_empty ? 8'd0  : r_q_status[r_rd_ptr];
  assign w_head_addr   = w_fault_empty ? 32'd0 : r_q_addr[r_rd_ptr];
  assign w_unused      = ^{scan_enable, test_mode, i_access_address[REGION_SHIFT-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FAULT_DEPTH; i++) begin
        r_q_status[i] <= '0;
        r_q_addr[i]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_status[r_wr_ptr] <= i_fault_status;
        r_q_addr[r_wr_ptr]   <= i_fault_address;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      if (w_fault_take && !w_push)
        r_ovf <= 1'b1;
      else if (w_mcr && (i_copro_crn == 4'd6))
        r_ovf <= 1'b0;
    end
  end
`else
  logic [7:0]  r_f_status;
  logic [31:0] r_f_addr;
  logic        r_f_valid;

  assign w_fault_empty = !r_f_valid;
  assign w_fault_ovf   = 1'b0;
  assign w_fault_cnt   = {3'd0, r_f_valid};
  assign w_head_status = r_f_status;
  assign w_head_addr   = r_f_addr;
  assign w_unused      = ^{scan_enable, test_mode, i_access_address[REGION_SHIFT-1:0], (FAULT_DEPTH > 0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_status <= '0;
      r_f_addr   <= '0;
      r_f_valid  <= 1'b0;
    end else if (w_fault_take) begin
      r_f_status <= i_fault_status;
      r_f_addr   <= i_fault_address;
      r_f_valid  <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_read_mux = 32'd0;
    case (i_copro_crn)
      4'd0:    w_read_mux = 32'h4156_0310;
      4'd1:    w_read_mux = {31'd0, r_flush_busy};
      4'd2:    w_read_mux = {29'd0, r_cache_control};
      4'd3:    w_read_mux = r_cacheable;
      4'd4:    w_read_mux = r_updateable;
      4'd5:    w_read_mux = r_disruptive;
      4'd6:    w_read_mux = {16'd0, w_fault_cnt, 2'd0, w_fault_ovf, w_fault_empty, w_head_status};
      4'd7:    w_read_mux = w_head_addr;
      default: w_read_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cache_control <= '0;
      r_cacheable     <= '0;
      r_updateable    <= '0;
      r_disruptive    <= '0;
      r_read_data     <= '0;
    end else begin
      if (w_mcr) begin
        case (i_copro_crn)
          4'd2:    r_cache_control <= i_copro_write_data[2:0];
          4'd3:    r_cacheable     <= i_copro_write_data & MAP_MASK;
          4'd4:    r_updateable    <= i_copro_write_data & MAP_MASK;
          4'd5:    r_disruptive    <= i_copro_write_data & MAP_MASK;
          default: ;
        endcase
      end
      if (w_mrc)
        r_read_data <= w_read_mux;
    end
  end

  // An ack-cycle trigger is remembered in r_flush_pend so it re-requests after one IDLE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_state <= FL_IDLE;
      r_flush_pend  <= 1'b0;
      r_flush_req   <= 1'b0;
      r_flush_busy  <= 1'b0;
    end else begin
      case (r_flush_state)
        FL_IDLE: begin
          if (w_trigger || r_flush_pend) begin
            r_flush_state <= FL_REQ;
            r_flush_req   <= 1'b1;
            r_flush_busy  <= 1'b1;
            r_flush_pend  <= 1'b0;
          end
        end
        FL_REQ, FL_WAIT: begin
          if (i_cache_flush_ack) begin
            r_flush_state <= FL_IDLE;
            r_flush_req   <= 1'b0;
            r_flush_busy  <= 1'b0;
            r_flush_pend  <= w_trigger;
          end else begin
            r_flush_state <= FL_WAIT;
          end
        end
        default: begin
          r_flush_state <= FL_IDLE;
          r_flush_req   <= 1'b0;
          r_flush_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_copro_read_data = r_read_data;
  assign o_cache_enable    = r_cache_control[0];
  assign o_cacheable_area  = r_cacheable;
  assign o_cache_flush_req = r_flush_req;
  assign o_flush_busy      = r_flush_busy;

endmodule

// File: tb/tb_a25_copro15_regfile.sv
// Directed self-checking bench for a25_copro15_regfile with NUM_REGIONS=8, REGION_SHIFT=21, FAULT_DEPTH=4.
// Fault checks follow A25_COPRO_FAULT_QUEUE_EN when defined.
module tb_a25_copro15_regfile;
  logic        clk;
  logic        reset;
  logic        scan_enable;
  logic        test_mode;
  logic        i_core_stall;
  logic [3:0]  i_copro_crn;
  logic [1:0]  i_copro_operation;
  logic [31:0] i_copro_write_data;
  logic        i_fault;
  logic [7:0]  i_fault_status;
  logic [31:0] i_fault_address;
  logic        i_access_valid;
  logic [31:0] i_access_address;
  logic        i_cache_flush_ack;
  logic [31:0] o_copro_read_data;
  logic        o_cache_enable;
  logic [31:0] o_cacheable_area;
  logic        o_cache_flush_req;
  logic        o_flush_busy;

  int n_cmp = 0;
  int n_err = 0;

  a25_copro15_regfile #(.NUM_REGIONS(8), .REGION_SHIFT(21), .FAULT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .scan_enable(scan_enable), .test_mode(test_mode),
    .i_core_stall(i_core_stall), .i_copro_crn(i_copro_crn), .i_copro_operation(i_copro_operation),
    .i_copro_write_data(i_copro_write_data), .i_fault(i_fault), .i_fault_status(i_fault_status),
    .i_fault_address(i_fault_address), .i_access_valid(i_access_valid),
    .i_access_address(i_access_address), .i_cache_flush_ack(i_cache_flush_ack),
    .o_copro_read_data(o_copro_read_data), .o_cache_enable(o_cache_enable),
    .o_cacheable_area(o_cacheable_area), .o_cache_flush_req(o_cache_flush_req),
    .o_flush_busy(o_flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [3:0] crn, input logic [31:0] wd);
    i_copro_operation  = op;
    i_copro_crn        = crn;
    i_copro_write_data = wd;
    cyc();
    i_copro_operation  = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scan_enable = 1'b0; test_mode = 1'b0; i_core_stall = 1'b0;
    i_copro_crn = 4'd0; i_copro_operation = 2'd0; i_copro_write_data = 32'd0;
    i_fault = 1'b0; i_fault_status = 8'd0; i_fault_address = 32'd0;
    i_access_valid = 1'b0; i_access_address = 32'd0; i_cache_flush_ack = 1'b0;
    cyc(); cyc();
    n_cmp++; if (o_copro_read_data !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want %h", o_copro_read_data, 32'd0); end
    n_cmp++; if (o_cache_enable !== 1'b0) begin n_err++; $display("FAIL reset_cen: got %b want 0", o_cache_enable); end
    n_cmp++; if (o_cacheable_area !== 32'd0) begin n_err++; $display("FAIL reset_area: got %h want 0", o_cacheable_area); end
    n_cmp++; if (o_cache_flush_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", o_cache_flush_req); end
    n_cmp++; if (o_flush_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_flush_busy); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_id_read();
    do_op(2'd1, 4'd0, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h4156_0310) begin n_err++; $display("FAIL id_crn0: got %h want %h", o_copro_read_data, 32'h4156_0310); end
    do_op(2'd1, 4'd2, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'd0) begin n_err++; $display("FAIL ctrl_crn2: got %h want 0", o_copro_read_data); end
    do_op(2'd1, 4'd6, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_0100) begin n_err++; $display("FAIL fault_empty_crn6: got %h want %h", o_copro_read_data, 32'h0000_0100); end
    do_op(2'd1, 4'd9, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'd0) begin n_err++; $display("FAIL unmapped_crn9: got %h want 0", o_copro_read_data); end
  endtask

  task automatic test_map_mask();
    do_op(2'd2, 4'd3, 32'hFFFF_FFFF);
    do_op(2'd1, 4'd3, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_00FF) begin n_err++; $display("FAIL map_crn3: got %h want %h", o_copro_read_data, 32'h0000_00FF); end
    n_cmp++; if (o_cacheable_area !== 32'h0000_00FF) begin n_err++; $display("FAIL map_area: got %h want %h", o_cacheable_area, 32'h0000_00FF); end
    do_op(2'd2, 4'd4, 32'h1234_5678);
    do_op(2'd1, 4'd4, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_0078) begin n_err++; $display("FAIL map_crn4: got %h want %h", o_copro_read_data, 32'h0000_0078); end
  endtask

  task automatic test_flush_mcr();
    int high_cnt;
    high_cnt = 0;
    do_op(2'd2, 4'd1, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (o_cache_flush_req === 1'b1) high_cnt++;
      if (i == 1) begin
        n_cmp++; if (o_flush_busy !== 1'b1) begin n_err++; $display("FAIL flush_busy: got %b want 1", o_flush_busy); end
      end
      if (i == 4) begin
        n_cmp++; if (o_copro_read_data !== 32'd1) begin n_err++; $display("FAIL flush_crn1_busy: got %h want 1", o_copro_read_data); end
      end
      if (i == 2) begin i_copro_operation = 2'd2; i_copro_crn = 4'd1; end
      if (i == 3) begin i_copro_operation = 2'd1; i_copro_crn = 4'd1; end
      if (i == 5) i_cache_flush_ack = 1'b1;
      cyc();
      i_copro_operation = 2'd0;
    end
    i_cache_flush_ack = 1'b0;
    n_cmp++; if (high_cnt !== 6) begin n_err++; $display("FAIL flush_req_len: got %0d want 6", high_cnt); end
    n_cmp++; if (o_cache_flush_req !== 1'b0) begin n_err++; $display("FAIL flush_req_drop: got %b want 0", o_cache_flush_req); end
    high_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (o_cache_flush_req === 1'b1) high_cnt++;
    end
    n_cmp++; if (high_cnt !== 0) begin n_err++; $display("FAIL flush_merged: got %0d extra req cycles want 0", high_cnt); end
  endtask

  task automatic test_ack_merge();
    do_op(2'd2, 4'd1, 32'd0);
    i_cache_flush_ack = 1'b1;
    do_op(2'd2, 4'd1, 32'd0);
    i_cache_flush_ack = 1'b0;
    n_cmp++; if (o_cache_flush_req !== 1'b0) begin n_err++; $display("FAIL ackmerge_idle: got %b want 0", o_cache_flush_req); end
    cyc();
    n_cmp++; if (o_cache_flush_req !== 1'b1) begin n_err++; $display("FAIL ackmerge_rereq: got %b want 1", o_cache_flush_req); end
    i_cache_flush_ack = 1'b1;
    cyc();
    i_cache_flush_ack = 1'b0;
    cyc();
    n_cmp++; if (o_cache_flush_req !== 1'b0) begin n_err++; $display("FAIL ackmerge_done: got %b want 0", o_cache_flush_req); end
  endtask

  task automatic test_disruptive();
    do_op(2'd2, 4'd2, 32'd1);
    do_op(2'd2, 4'd5, 32'h0000_0002);
    n_cmp++; if (o_cache_enable !== 1'b1) begin n_err++; $display("FAIL disr_cen: got %b want 1", o_cache_enable); end
    i_access_valid = 1'b1; i_access_address = 32'h0020_0000;
    cyc();
    i_access_valid = 1'b0;
    n_cmp++; if (o_cache_flush_req !== 1'b1) begin n_err++; $display("FAIL disr_hit: got %b want 1", o_cache_flush_req); end
    i_cache_flush_ack = 1'b1;
    cyc();
    i_cache_flush_ack = 1'b0;
    i_access_valid = 1'b1; i_access_address = 32'h0040_0000;
    cyc();
    n_cmp++; if (o_cache_flush_req !== 1'b0) begin n_err++; $display("FAIL disr_miss: got %b want 0", o_cache_flush_req); end
    i_access_address = 32'h1020_0000;
    cyc();
    i_access_valid = 1'b0;
    n_cmp++; if (o_cache_flush_req !== 1'b0) begin n_err++; $display("FAIL disr_oob: got %b want 0", o_cache_flush_req); end
  endtask

  task automatic test_faults();
`ifdef A25_COPRO_FAULT_QUEUE_EN
    logic [31:0] exp_addr [5];
    for (int i = 0; i < 5; i++) begin
      i_fault = 1'b1; i_fault_status = 8'h10 + 8'(i); i_fault_address = 32'h1000_0000 + 32'(i);
      cyc();
    end
    i_fault = 1'b0;
    do_op(2'd1, 4'd6, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_4210) begin n_err++; $display("FAIL q_full_crn6: got %h want %h", o_copro_read_data, 32'h0000_4210); end
    exp_addr[0] = 32'h1000_0000; exp_addr[1] = 32'h1000_0001; exp_addr[2] = 32'h1000_0002;
    exp_addr[3] = 32'h1000_0003; exp_addr[4] = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      do_op(2'd1, 4'd7, 32'd0);
      n_cmp++; if (o_copro_read_data !== exp_addr[i]) begin n_err++; $display("FAIL q_pop%0d: got %h want %h", i, o_copro_read_data, exp_addr[i]); end
    end
    do_op(2'd1, 4'd6, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_0300) begin n_err++; $display("FAIL q_empty_crn6: got %h want %h", o_copro_read_data, 32'h0000_0300); end
    do_op(2'd2, 4'd6, 32'd0);
    do_op(2'd1, 4'd6, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_0100) begin n_err++; $display("FAIL q_ovf_clear: got %h want %h", o_copro_read_data, 32'h0000_0100); end
`else
    i_fault = 1'b1; i_fault_status = 8'h5A; i_fault_address = 32'h1234_5678;
    cyc();
    i_fault = 1'b0;
    do_op(2'd1, 4'd6, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_105A) begin n_err++; $display("FAIL f1_crn6: got %h want %h", o_copro_read_data, 32'h0000_105A); end
    do_op(2'd1, 4'd7, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h1234_5678) begin n_err++; $display("FAIL f1_crn7: got %h want %h", o_copro_read_data, 32'h1234_5678); end
    do_op(2'd1, 4'd7, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h1234_5678) begin n_err++; $display("FAIL f1_nopop: got %h want %h", o_copro_read_data, 32'h1234_5678); end
    i_fault = 1'b1; i_fault_status = 8'hA5; i_fault_address = 32'hCAFE_0000;
    cyc();
    i_fault = 1'b0;
    do_op(2'd1, 4'd6, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'h0000_10A5) begin n_err++; $display("FAIL f2_crn6: got %h want %h", o_copro_read_data, 32'h0000_10A5); end
    do_op(2'd1, 4'd7, 32'd0);
    n_cmp++; if (o_copro_read_data !== 32'hCAFE_0000) begin n_err++; $display("FAIL f2_crn7: got %h want %h", o_copro_read_data, 32'hCAFE_0000); end
`endif
  endtask

  task automatic test_stall();
    logic [31:0] exp_crn6;
`ifdef A25_COPRO_FAULT_QUEUE_EN
    exp_crn6 = 32'h0000_0100;
`else
    exp_crn6 = 32'h0000_10A5;
`endif
    do_op(2'd1, 4'd0, 32'd0);
    i_core_stall = 1'b1;
    i_copro_operation = 2'd2; i_copro_crn = 4'd3; i_copro_write_data = 32'd0;
    i_fault = 1'b1; i_fault_status = 8'h77; i_fault_address = 32'hDEAD_0000;
    cyc();
    i_copro_operation = 2'd1; i_copro_crn = 4'd2;
    cyc();
    i_copro_operation = 2'd0; i_fault = 1'b0; i_core_stall = 1'b0;
    n_cmp++; if (o_copro_read_data !== 32'h4156_0310) begin n_err++; $display("FAIL stall_rdata_held: got %h want %h", o_copro_read_data, 32'h4156_0310); end
    n_cmp++; if (o_cacheable_area !== 32'h0000_00FF) begin n_err++; $display("FAIL stall_area: got %h want %h", o_cacheable_area, 32'h0000_00FF); end
    do_op(2'd1, 4'd6, 32'd0);
    n_cmp++; if (o_copro_read_data !== exp_crn6) begin n_err++; $display("FAIL stall_fault: got %h want %h", o_copro_read_data, exp_crn6); end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_map_mask();
    test_flush_mcr();
    test_ack_merge();
    test_disruptive();
    test_faults();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
